gate_bist_ctrl: RTL and testbench
=================================

Name: gate_bist_ctrl

Overview:
- Synthesizable built-in self-test controller for any 2-input combinational gate in the library (NAND by default).
- Drives the gate's A/B inputs through all four input combinations and samples Y after a settle window.
- Compares each sample against a parameterized truth table and reports pass/fail, a per-vector failure mask and an error count.
- Sits beside the gate under test as the on-chip stimulus/response end of the gate-check flow. The gate is instantiated outside this block, with A/B fed from it and Y returned to it.

Parameters:
- TRUTH_TABLE, 4'b0111: expected Y per vector; bit index = {A,B}. The default is NAND: 00/01/10 give 1, 11 gives 0.
- SETTLE_CYCLES, 2: cycles each vector is held before the sample edge. Legal range 0..15.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request a test run; accepted only when busy==0
- A  output  1  gate-under-test input A, registered
- B  output  1  gate-under-test input B, registered
- Y  input  1  gate-under-test output, sampled synchronously
- busy  output  1  run in progress
- done  output  1  one-cycle pulse at run completion
- pass  output  1  last run matched all four vectors; held until next start
- fail_mask  output  4  bit i set if vector i={A,B} mismatched; held
- err_count  output  3  number of mismatching vectors, 0..4; held

Behaviour:
- Reset (async, rst_n=0): state IDLE; A=0, B=0, busy=0, done=0, pass=0, fail_mask=0, err_count=0, vector index=0, settle counter=0. Takes effect immediately, including mid-run. No partial result survives.
- States: IDLE, RUN, DONE. Internal 2-bit vec and 4-bit cnt.
- IDLE or DONE with start=1 at edge E0 → RUN:
  - busy=1, vec=0, {A,B}=2'b00, cnt=SETTLE_CYCLES
  - fail_mask, err_count and pass cleared to 0 at the same edge
- RUN, cnt!=0: cnt decrements by 1; A/B held.
- RUN, cnt==0 (sample edge): compare Y with TRUTH_TABLE[vec]. On mismatch, set fail_mask[vec] and increment err_count.
  - If vec<3: vec increments, {A,B}=vec+1, cnt reloads SETTLE_CYCLES.
  - If vec==3: go to DONE.
- Each vector is held SETTLE_CYCLES+1 cycles. Vector k is sampled at edge E0+(k+1)*(SETTLE_CYCLES+1).
- Entering DONE (edge E0+4*(SETTLE_CYCLES+1)):
  - busy=0, done=1 for exactly one cycle, {A,B}=00
  - pass=1 iff final fail_mask==0
  - The final vector's mismatch is included in fail_mask, err_count and pass at this same edge.
- DONE → IDLE next edge unless start=1, which begins a new run directly (back-to-back runs allowed).
- start while busy=1 is ignored. The run is not restarted and the results are not cleared.
- start held high continuously: a new run begins on the edge after each done.
- SETTLE_CYCLES=0: each vector is held one cycle and sampled at the very next edge. The run occupies 4 cycles.
- Y is used only at sample edges. Y changes between sample edges have no effect.
- Outputs fail_mask, err_count and pass are stable from done until the next accepted start.

Test Plan:
- Correct NAND model on Y, SETTLE_CYCLES=2: pulse start at E0 → A/B step 00,01,10,11 every 3 cycles; done at E12; pass=1, fail_mask=0000, err_count=0.
- Y stuck at 1 with NAND expectation → fail_mask=1000, err_count=1, pass=0. Rerun with a correct model → pass=1 and mask cleared at start.
- AND model on Y with TRUTH_TABLE default → fail_mask=1111, err_count=4, pass=0. Same model with TRUTH_TABLE=4'b1000 → pass=1.
- start pulsed again at E4 during a run → ignored; done still at E12. start held high → second run begins at E13 (busy=1, A/B=00) with results cleared.
- rst_n low at E7 mid-run → A=B=0, busy=0, done=0, mask/count/pass=0 immediately. After release, the next start yields a full fresh run.
- SETTLE_CYCLES=0, correct NAND → each vector held 1 cycle; done at E4; pass=1.

Source files
------------

// File: rtl/gate_bist_ctrl.sv
// BIST controller for a 2-input gate: walks {A,B} through 00..11 and checks Y against TRUTH_TABLE.
// Latency: 4*(SETTLE_CYCLES+1) cycles from the accepted start to the done pulse.
// Backpressure: none; start is accepted only while not busy, and a start during a run is dropped.
module gate_bist_ctrl #(
    parameter logic [3:0] TRUTH_TABLE   = 4'b0111,
    parameter int         SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       A,
    output logic       B,
    input  logic       Y,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] fail_mask,
    output logic [2:0] err_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [3:0] SETTLE = 4'(SETTLE_CYCLES);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [1:0] r_vec;
    logic [3:0] r_cnt;
    logic       r_a;
    logic       r_b;
    logic       r_pass;
    logic [3:0] r_mask;
    logic [2:0] r_err;

    logic       w_accept;
    logic       w_sample;
    logic       w_mismatch;
    logic       w_last;
    logic [3:0] w_mask_nxt;

    // A run may be (re)started from IDLE or straight out of DONE, never mid-run.
    assign w_accept   = start && (r_state != ST_RUN);
    assign w_sample   = (r_state == ST_RUN) && (r_cnt == 4'd0);
    assign w_mismatch = w_sample && (Y != TRUTH_TABLE[r_vec]);
    assign w_last     = w_sample && (r_vec == 2'd3);
    // Mask including the vector being sampled now, so the final pass can see the last vector.
    assign w_mask_nxt = r_mask | (w_mismatch ? (4'b0001 << r_vec) : 4'b0000);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: DONE lasts one cycle unless start chains straight into another run.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (start) w_state_nxt = ST_RUN;
            ST_RUN:  if (w_last) w_state_nxt = ST_DONE;
            ST_DONE: w_state_nxt = start ? ST_RUN : ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Output decode: status from state, stimulus and results straight from their registers.
    always_comb begin
        busy      = (r_state == ST_RUN);
        done      = (r_state == ST_DONE);
        A         = r_a;
        B         = r_b;
        pass      = r_pass;
        fail_mask = r_mask;
        err_count = r_err;
    end

    // Datapath: settle counter, vector stepping, result accumulation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vec  <= 2'd0;
            r_cnt  <= 4'd0;
            r_a    <= 1'b0;
            r_b    <= 1'b0;
            r_pass <= 1'b0;
            r_mask <= 4'd0;
            r_err  <= 3'd0;
        end else if (w_accept) begin
            r_vec  <= 2'd0;
            r_cnt  <= SETTLE;
            r_a    <= 1'b0;
            r_b    <= 1'b0;
            r_pass <= 1'b0;
            r_mask <= 4'd0;
            r_err  <= 3'd0;
        end else if (r_state == ST_RUN) begin
            if (r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end else begin
                r_mask <= w_mask_nxt;
                if (w_mismatch) begin
                    r_err <= r_err + 3'd1;
                end
                if (r_vec != 2'd3) begin
                    r_vec      <= r_vec + 2'd1;
                    {r_a, r_b} <= r_vec + 2'd1;
                    r_cnt      <= SETTLE;
                end else begin
                    {r_a, r_b} <= 2'b00;
                    r_pass     <= (w_mask_nxt == 4'd0);
                end
            end
        end
    end

endmodule

// File: tb/tb_gate_bist_ctrl.sv
module tb_gate_bist_ctrl;

    localparam int         S_OF  [3] = '{2, 0, 3};
    localparam logic [3:0] TT_OF [3] = '{4'b0111, 4'b0111, 4'b1000};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] start_r = 3'b000;
    logic [2:0] y_r = 3'b000;
    logic [2:0] a_w, b_w, busy_w, done_w, pass_w;
    logic [3:0] mask_w [3];
    logic [2:0] err_w  [3];

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    gate_bist_ctrl #(.TRUTH_TABLE(4'b0111), .SETTLE_CYCLES(2)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start_r[0]), .A(a_w[0]), .B(b_w[0]), .Y(y_r[0]),
        .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]), .fail_mask(mask_w[0]), .err_count(err_w[0]));

    gate_bist_ctrl #(.TRUTH_TABLE(4'b0111), .SETTLE_CYCLES(0)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_r[1]), .A(a_w[1]), .B(b_w[1]), .Y(y_r[1]),
        .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]), .fail_mask(mask_w[1]), .err_count(err_w[1]));

    gate_bist_ctrl #(.TRUTH_TABLE(4'b1000), .SETTLE_CYCLES(3)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start_r[2]), .A(a_w[2]), .B(b_w[2]), .Y(y_r[2]),
        .busy(busy_w[2]), .done(done_w[2]), .pass(pass_w[2]), .fail_mask(mask_w[2]), .err_count(err_w[2]));

    typedef struct {
        int         d;
        logic [3:0] gate;
        bit         mid;
        bit         hold;
        logic [3:0] e_mask;
        logic [2:0] e_err;
        bit         e_pass;
    } vec_t;

    task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s dut%0d @%0t: got %0h expected %0h", nm, d, $time, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string nm);
        for (int i = 0; i < 3; i++) begin
            chk(nm, i, {busy_w[i], done_w[i], a_w[i], b_w[i], pass_w[i], mask_w[i], err_w[i]}, 32'd0);
        end
    endtask

    // One run on dut d with a gate whose truth table is 'gate'. Expected timeline comes from
    // the run geometry: vector k occupies cycles k*(S+1)..(k+1)*(S+1)-1 after the start edge.
    task automatic run(input int d, input logic [3:0] gate, input bit noise, input bit mid,
                       input bit hold, input int abort_at,
                       input logic [3:0] e_mask, input logic [2:0] e_err, input bit e_pass);
        int         s1;
        int         len;
        int         r;
        logic [3:0] ev;
        s1  = S_OF[d] + 1;
        len = 4 * s1;
        start_r[d] = 1'b1;
        y_r[d] = 1'($urandom);
        @(posedge clk);
        for (int m = 0; m <= len + 1; m++) begin
            @(negedge clk);
            if (m == abort_at) begin
                rst_n = 1'b0;
                #1;
                chk_all_zero("async_reset");
                start_r[d] = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            if (m <= len) begin
                ev = {(m < len), (m == len), (m < len) ? 2'(m / s1) : 2'b00};
                chk("timeline", d, {busy_w[d], done_w[d], a_w[d], b_w[d]}, {28'd0, ev});
            end
            if (m == 0)
                chk("clear_at_start", d, {pass_w[d], mask_w[d], err_w[d]}, 32'd0);
            if (m == len)
                chk("result", d, {pass_w[d], mask_w[d], err_w[d]}, {24'd0, e_pass, e_mask, e_err});
            if (m == len + 1) begin
                if (hold)
                    chk("back_to_back", d, {busy_w[d], done_w[d], a_w[d], b_w[d], pass_w[d], mask_w[d], err_w[d]},
                        {20'd0, 4'b1000, 8'd0});
                else
                    chk("idle_hold", d, {busy_w[d], done_w[d], pass_w[d], mask_w[d], err_w[d]},
                        {23'd0, 2'b00, e_pass, e_mask, e_err});
            end
            start_r[d] = hold || (mid && m == 3);
            r = m + 1;
            if (r % s1 == 0 && r / s1 >= 1 && r / s1 <= 4)
                y_r[d] = gate[r / s1 - 1];
            else if (noise)
                y_r[d] = 1'($urandom);
            else
                y_r[d] = gate[{a_w[d], b_w[d]}];
        end
        start_r[d] = 1'b0;
        if (hold) begin
            for (int k = 0; k < len + 2; k++) @(negedge clk);
        end
    endtask

    vec_t       tbl [10];
    int         d;
    logic [3:0] g;
    logic [3:0] em;

    initial begin
        tbl[0] = '{0, 4'b0111, 1'b0, 1'b0, 4'b0000, 3'd0, 1'b1};
        tbl[1] = '{0, 4'b1111, 1'b0, 1'b0, 4'b1000, 3'd1, 1'b0};
        tbl[2] = '{0, 4'b0111, 1'b0, 1'b0, 4'b0000, 3'd0, 1'b1};
        tbl[3] = '{0, 4'b1000, 1'b0, 1'b0, 4'b1111, 3'd4, 1'b0};
        tbl[4] = '{2, 4'b1000, 1'b0, 1'b0, 4'b0000, 3'd0, 1'b1};
        tbl[5] = '{1, 4'b0111, 1'b0, 1'b0, 4'b0000, 3'd0, 1'b1};
        tbl[6] = '{1, 4'b0000, 1'b0, 1'b0, 4'b0111, 3'd3, 1'b0};
        tbl[7] = '{2, 4'b0110, 1'b0, 1'b0, 4'b1110, 3'd3, 1'b0};
        tbl[8] = '{0, 4'b0000, 1'b1, 1'b0, 4'b0111, 3'd3, 1'b0};
        tbl[9] = '{0, 4'b0111, 1'b0, 1'b1, 4'b0000, 3'd0, 1'b1};

        #12;
        chk_all_zero("reset_state");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            run(tbl[i].d, tbl[i].gate, 1'b0, tbl[i].mid, tbl[i].hold, -1,
                tbl[i].e_mask, tbl[i].e_err, tbl[i].e_pass);
        end

        // Reset mid-run with partial failures accumulated, then a full fresh run.
        run(0, 4'b0000, 1'b0, 1'b0, 1'b0, 7, 4'b0111, 3'd3, 1'b0);
        @(negedge clk);
        run(0, 4'b0111, 1'b0, 1'b0, 1'b0, -1, 4'b0000, 3'd0, 1'b1);

        // Random gates with random Y between sample edges.
        for (int i = 0; i < 24; i++) begin
            d  = $urandom_range(0, 2);
            g  = 4'($urandom);
            em = g ^ TT_OF[d];
            run(d, g, 1'b1, 1'b0, 1'b0, -1, em, 3'($countones(em)), (em == 4'd0));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
